// File: rtl/cpu_types_pkg.sv
// Shared CPU types: pipeline latch controls, hazard FSM states and opcodes.
// Used by the hazard unit and the datapath latches it drives.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    PIPE_ENABLE = 2'd0,
    PIPE_STALL  = 2'd1,
    PIPE_NOP    = 2'd2
  } pipe_state_t;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MEMWAIT    = 2'd1,
    REDIR_PEND = 2'd2,
    HALTED     = 2'd3
  } hazard_state_t;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    ADDI  = 6'h08,
    ADDIU = 6'h09,
    SLTI  = 6'h0a,
    SLTIU = 6'h0b,
    ANDI  = 6'h0c,
    ORI   = 6'h0d,
    XORI  = 6'h0e,
    LUI   = 6'h0f,
    LW    = 6'h23,
    SW    = 6'h2b,
    HALT  = 6'h3f
  } opcode_t;

  function automatic logic is_mem_op(input opcode_t op);
    return (op == LW) || (op == SW);
  endfunction

endpackage

// File: rtl/fwd_select.sv
// Priority match of one ALU source register against the forwarding stages.
// Combinational; the nearest (lowest-index) writing stage wins, register 0 never forwards.
module fwd_select #(
  parameter int  REG_W     = 5,
  parameter int  FWD_DEPTH = 2,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic [REG_W-1:0]                src,
  input  logic [FWD_DEPTH-1:0][REG_W-1:0] wsel,
  input  logic [FWD_DEPTH-1:0]            wen,
  output logic [SEL_W-1:0]                sel
);

  // Walk from oldest to nearest so the nearest match overwrites older ones.
  always_comb begin
    sel = '0;
    if (src != '0) begin
      for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
        if (wen[k] && (wsel[k] == src)) begin
          sel = SEL_W'(k + 1);
        end
      end
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: latch controls, PC write enable, forwarding selects, perf counters.
// Controls and selects are combinational; state, halted and counters update on CLK.
module hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int  REG_W     = 5,
  parameter int  FWD_DEPTH = 2,
  parameter int  CNT_W     = 16,
  localparam int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            ihit,
  input  logic                            dhit,
  input  logic [REG_W-1:0]                d_rs,
  input  logic [REG_W-1:0]                d_rt,
  input  logic [REG_W-1:0]                e_rs,
  input  logic [REG_W-1:0]                e_rt,
  input  logic                            e_memread,
  input  logic [REG_W-1:0]                e_wsel,
  input  logic [FWD_DEPTH-1:0][REG_W-1:0] fwd_wsel,
  input  logic [FWD_DEPTH-1:0]            fwd_wen,
  input  logic                            m_memreq,
  input  logic                            redirect,
  input  logic                            w_halt,
  output logic                            pc_wen,
  output pipe_state_t                     fd_state,
  output pipe_state_t                     de_state,
  output pipe_state_t                     em_state,
  output pipe_state_t                     mw_state,
  output logic [SEL_W-1:0]                fsel_a,
  output logic [SEL_W-1:0]                fsel_b,
  output logic                            halted,
  output logic [CNT_W-1:0]                stall_cnt,
  output logic [CNT_W-1:0]                flush_cnt
);

  hazard_state_t    state_q, state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             flush_evt;
  logic             load_use;

  assign load_use = e_memread && (e_wsel != '0) &&
                    ((e_wsel == d_rs) || (e_wsel == d_rt));

  always_comb begin
    fd_state  = PIPE_ENABLE;
    de_state  = PIPE_ENABLE;
    em_state  = PIPE_ENABLE;
    mw_state  = PIPE_ENABLE;
    pc_wen    = 1'b1;
    state_d   = RUN;
    flush_evt = 1'b0;
    if (RST) begin
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      mw_state = PIPE_NOP;
      pc_wen   = 1'b0;
    end else if ((state_q == HALTED) || w_halt) begin
      fd_state = PIPE_NOP;
      de_state = PIPE_NOP;
      em_state = PIPE_NOP;
      mw_state = PIPE_NOP;
      pc_wen   = 1'b0;
      state_d  = HALTED;
    end else if (redirect || (state_q == REDIR_PEND)) begin
      // A flush needs a valid fetch at the target; hold it pending across I-misses.
      if (ihit) begin
        fd_state  = PIPE_NOP;
        de_state  = PIPE_NOP;
        em_state  = PIPE_NOP;
        flush_evt = 1'b1;
      end else begin
        fd_state = PIPE_STALL;
        de_state = PIPE_STALL;
        em_state = PIPE_STALL;
        mw_state = PIPE_STALL;
        pc_wen   = 1'b0;
        state_d  = REDIR_PEND;
      end
    end else if (m_memreq && !dhit) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_STALL;
      pc_wen   = 1'b0;
      state_d  = MEMWAIT;
    end else if (m_memreq) begin
      if (!ihit) begin
        fd_state = PIPE_NOP;
      end
      pc_wen = ihit;
    end else if (!ihit) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_STALL;
      em_state = PIPE_STALL;
      mw_state = PIPE_STALL;
      pc_wen   = 1'b0;
    end else if (load_use) begin
      fd_state = PIPE_STALL;
      de_state = PIPE_NOP;
      pc_wen   = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if ((fd_state != PIPE_ENABLE) && (state_q != HALTED) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
    if (flush_evt && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign halted    = (state_q == HALTED);
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  fwd_select #(
    .REG_W    (REG_W),
    .FWD_DEPTH(FWD_DEPTH)
  ) u_fwd_a (
    .src (e_rs),
    .wsel(fwd_wsel),
    .wen (fwd_wen),
    .sel (fsel_a)
  );

  fwd_select #(
    .REG_W    (REG_W),
    .FWD_DEPTH(FWD_DEPTH)
  ) u_fwd_b (
    .src (e_rt),
    .wsel(fwd_wsel),
    .wen (fwd_wen),
    .sel (fsel_b)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios plus a randomized run
// against a rule-level reference model.
module tb_hazard_ctrl;
  import cpu_types_pkg::*;

  localparam int REG_W = 5;
  localparam int FWD_DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = 15;

  logic CLK = 1'b0;
  logic RST;
  logic ihit, dhit, e_memread, m_memreq, redirect, w_halt;
  logic [REG_W-1:0] d_rs, d_rt, e_rs, e_rt, e_wsel;
  logic [FWD_DEPTH-1:0][REG_W-1:0] fwd_wsel;
  logic [FWD_DEPTH-1:0] fwd_wen;
  logic pc_wen, halted;
  pipe_state_t fd_state, de_state, em_state, mw_state;
  logic [1:0] fsel_a, fsel_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int n_assert = 0;
  int n_fail = 0;

  // Reference model state: sticky halt, pending flush, counter values.
  bit m_halted, m_pend;
  int m_stall, m_flush;

  always #5 CLK = ~CLK;

  hazard_ctrl #(.REG_W(REG_W), .FWD_DEPTH(FWD_DEPTH), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .d_rs(d_rs), .d_rt(d_rt),
    .e_rs(e_rs), .e_rt(e_rt), .e_memread(e_memread), .e_wsel(e_wsel),
    .fwd_wsel(fwd_wsel), .fwd_wen(fwd_wen), .m_memreq(m_memreq),
    .redirect(redirect), .w_halt(w_halt), .pc_wen(pc_wen),
    .fd_state(fd_state), .de_state(de_state), .em_state(em_state),
    .mw_state(mw_state), .fsel_a(fsel_a), .fsel_b(fsel_b), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  function automatic logic [8:0] ctl_word(input pipe_state_t fd, input pipe_state_t de,
                                          input pipe_state_t em, input pipe_state_t mw,
                                          input logic pc);
    return {fd, de, em, mw, pc};
  endfunction

  function automatic logic [8:0] dut_ctl();
    return {fd_state, de_state, em_state, mw_state, pc_wen};
  endfunction

  // Expected controls, straight from the priority list.
  function automatic logic [8:0] exp_ctl(output bit flush, output bit to_halt, output bit to_pend);
    flush = 0; to_halt = 0; to_pend = 0;
    if (RST) return ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0);
    if (m_halted || w_halt) begin
      to_halt = 1;
      return ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0);
    end
    if (redirect || m_pend) begin
      if (ihit) begin
        flush = 1;
        return ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b1);
      end
      to_pend = 1;
      return ctl_word(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
    end
    if (m_memreq && !dhit) return ctl_word(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
    if (m_memreq) return ctl_word(ihit ? PIPE_ENABLE : PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, ihit);
    if (!ihit) return ctl_word(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0);
    if (e_memread && e_wsel != 0 && (e_wsel == d_rs || e_wsel == d_rt))
      return ctl_word(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0);
    return ctl_word(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1);
  endfunction

  function automatic int exp_fsel(input logic [REG_W-1:0] src);
    if (src == 0) return 0;
    for (int k = 0; k < FWD_DEPTH; k++)
      if (fwd_wen[k] && fwd_wsel[k] == src) return k + 1;
    return 0;
  endfunction

  task automatic set_idle();
    ihit = 1; dhit = 1; e_memread = 0; m_memreq = 0; redirect = 0; w_halt = 0;
    d_rs = 0; d_rt = 0; e_rs = 0; e_rt = 0; e_wsel = 0; fwd_wsel = '0; fwd_wen = '0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1; set_idle();
    tick(); tick();
    RST = 0;
  endtask

  task automatic test_reset();
    RST = 1; set_idle();
    #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0)) begin
      n_fail++; $display("FAIL reset_ctl: got %b want all NOP, pc_wen 0", dut_ctl());
    end
    tick();
    n_assert++;
    if ({halted, stall_cnt, flush_cnt, fsel_a, fsel_b} !== '0) begin
      n_fail++; $display("FAIL reset_state: halted %b stall %0d flush %0d fsel %0d/%0d, want all 0",
                         halted, stall_cnt, flush_cnt, fsel_a, fsel_b);
    end
    RST = 0;
  endtask

  task automatic test_forwarding();
    set_idle();
    e_rs = 5; fwd_wsel[0] = 5; fwd_wsel[1] = 5; fwd_wen = 2'b11; #1;
    n_assert++;
    if (fsel_a !== 2'd1) begin n_fail++; $display("FAIL fwd_nearest: got %0d want 1", fsel_a); end
    fwd_wen = 2'b10; #1;
    n_assert++;
    if (fsel_a !== 2'd2) begin n_fail++; $display("FAIL fwd_oldest: got %0d want 2", fsel_a); end
    e_rs = 0; fwd_wsel = '0; fwd_wen = 2'b11; #1;
    n_assert++;
    if (fsel_a !== 2'd0) begin n_fail++; $display("FAIL fwd_r0: got %0d want 0", fsel_a); end
    e_rt = 7; fwd_wsel[0] = 6; fwd_wsel[1] = 7; #1;
    n_assert++;
    if (fsel_b !== 2'd2) begin n_fail++; $display("FAIL fwd_b: got %0d want 2", fsel_b); end
    set_idle();
  endtask

  task automatic test_load_use();
    do_reset();
    e_memread = 1; e_wsel = 3; d_rt = 3; #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_STALL, PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, 1'b0)) begin
      n_fail++; $display("FAIL load_use: got %b want fd STALL de NOP em/mw ENABLE pc 0", dut_ctl());
    end
    tick();
    e_memread = 0; e_wsel = 0; #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)) begin
      n_fail++; $display("FAIL load_use_clear: got %b want all ENABLE pc 1", dut_ctl());
    end
  endtask

  task automatic test_redirect_pending();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      redirect = 1; ihit = 0; #2;
      n_assert++;
      if (dut_ctl() !== ctl_word(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0)) begin
        n_fail++; $display("FAIL redir_wait%0d: got %b want all STALL pc 0", i, dut_ctl());
      end
      tick();
    end
    redirect = 0; ihit = 1; #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_ENABLE, 1'b1)) begin
      n_fail++; $display("FAIL redir_flush: got %b want NOP NOP NOP ENABLE pc 1", dut_ctl());
    end
    tick();
    n_assert++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd4) begin
      n_fail++; $display("FAIL redir_counts: flush %0d stall %0d want 1 and 4", flush_cnt, stall_cnt);
    end
    #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)) begin
      n_fail++; $display("FAIL redir_done: got %b want all ENABLE pc 1", dut_ctl());
    end
  endtask

  task automatic test_memwait();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      m_memreq = 1; dhit = 0; ihit = 1; #2;
      n_assert++;
      if (dut_ctl() !== ctl_word(PIPE_STALL, PIPE_STALL, PIPE_STALL, PIPE_STALL, 1'b0)) begin
        n_fail++; $display("FAIL memwait%0d: got %b want all STALL pc 0", i, dut_ctl());
      end
      tick();
    end
    dhit = 1; ihit = 0; #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_NOP, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b0)) begin
      n_fail++; $display("FAIL memdone: got %b want fd NOP others ENABLE pc 0", dut_ctl());
    end
    tick();
    n_assert++;
    if (stall_cnt !== 4'd5) begin n_fail++; $display("FAIL mem_stall_cnt: got %0d want 5", stall_cnt); end
    set_idle();
  endtask

  task automatic test_halt();
    do_reset();
    w_halt = 1; redirect = 1; #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0)) begin
      n_fail++; $display("FAIL halt_cycle: got %b want all NOP pc 0", dut_ctl());
    end
    tick();
    w_halt = 0; redirect = 0;
    n_assert++;
    if (halted !== 1'b1 || flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL halt_enter: halted %b flush %0d want 1 and 0", halted, flush_cnt);
    end
    for (int i = 0; i < 5; i++) begin
      redirect = 1'($urandom_range(0, 1)); m_memreq = 1'($urandom_range(0, 1)); #2;
      n_assert++;
      if (halted !== 1'b1 || dut_ctl() !== ctl_word(PIPE_NOP, PIPE_NOP, PIPE_NOP, PIPE_NOP, 1'b0)) begin
        n_fail++; $display("FAIL halt_hold%0d: halted %b ctl %b want 1 and all NOP", i, halted, dut_ctl());
      end
      tick();
    end
    RST = 1; set_idle();
    tick();
    RST = 0;
    n_assert++;
    if (halted !== 1'b0 || stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      n_fail++; $display("FAIL halt_reset: halted %b stall %0d flush %0d want 0", halted, stall_cnt, flush_cnt);
    end
    #2;
    n_assert++;
    if (dut_ctl() !== ctl_word(PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, PIPE_ENABLE, 1'b1)) begin
      n_fail++; $display("FAIL halt_run: got %b want all ENABLE pc 1", dut_ctl());
    end
  endtask

  task automatic test_saturation();
    do_reset();
    ihit = 0;
    for (int i = 0; i < 20; i++) tick();
    n_assert++;
    if (stall_cnt !== 4'd15) begin n_fail++; $display("FAIL stall_sat: got %0d want 15", stall_cnt); end
    do_reset();
    redirect = 1; ihit = 1;
    for (int i = 0; i < 20; i++) tick();
    n_assert++;
    if (flush_cnt !== 4'd15) begin n_fail++; $display("FAIL flush_sat: got %0d want 15", flush_cnt); end
    set_idle();
  endtask

  task automatic test_random();
    logic [8:0] e;
    bit fl, th, tp;
    int ea, eb;
    do_reset();
    m_halted = 0; m_pend = 0; m_stall = 0; m_flush = 0;
    for (int i = 0; i < 600; i++) begin
      RST = ($urandom_range(0, 39) == 0);
      ihit = ($urandom_range(0, 3) != 0);
      dhit = ($urandom_range(0, 2) != 0);
      m_memreq = ($urandom_range(0, 2) == 0);
      redirect = ($urandom_range(0, 7) == 0);
      w_halt = ($urandom_range(0, 99) == 0);
      e_memread = 1'($urandom_range(0, 1));
      d_rs = 5'($urandom_range(0, 3)); d_rt = 5'($urandom_range(0, 3));
      e_rs = 5'($urandom_range(0, 3)); e_rt = 5'($urandom_range(0, 3));
      e_wsel = 5'($urandom_range(0, 3));
      fwd_wsel[0] = 5'($urandom_range(0, 3)); fwd_wsel[1] = 5'($urandom_range(0, 3));
      fwd_wen = 2'($urandom_range(0, 3));
      #3;
      e = exp_ctl(fl, th, tp);
      ea = exp_fsel(e_rs); eb = exp_fsel(e_rt);
      n_assert++;
      if (dut_ctl() !== e) begin
        n_fail++; $display("FAIL rnd_ctl cyc %0d: got %b want %b", i, dut_ctl(), e);
      end
      n_assert++;
      if (fsel_a !== 2'(ea) || fsel_b !== 2'(eb)) begin
        n_fail++; $display("FAIL rnd_fsel cyc %0d: got %0d/%0d want %0d/%0d", i, fsel_a, fsel_b, ea, eb);
      end
      @(posedge CLK);
      if (RST) begin
        m_halted = 0; m_pend = 0; m_stall = 0; m_flush = 0;
      end else begin
        if (!m_halted && e[8:7] != 2'(PIPE_ENABLE) && m_stall < CNT_MAX) m_stall++;
        if (fl && m_flush < CNT_MAX) m_flush++;
        m_halted = th; m_pend = tp;
      end
      #1;
      n_assert++;
      if (halted !== m_halted || stall_cnt !== 4'(m_stall) || flush_cnt !== 4'(m_flush)) begin
        n_fail++; $display("FAIL rnd_state cyc %0d: halted %b stall %0d flush %0d want %b %0d %0d",
                           i, halted, stall_cnt, flush_cnt, m_halted, m_stall, m_flush);
      end
    end
    RST = 0; set_idle();
  endtask

  initial begin
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect_pending();
    test_memwait();
    test_halt();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Parametrised successor to the pipeline hazard unit. It generates per-latch pipe controls, PC write enable and ALU operand forwarding selects for a configurable number of forwarding stages. It adds state the earlier unit lacks: a load-use bubble, a pending-redirect register that holds a branch or jump flush across instruction-cache misses, a sticky halt state, and saturating stall and flush performance counters. It sits beside the datapath latches and drives every `*_state` and `fsel_*` input.

## Interface
- `REG_W`, 5: register-index width.
- `FWD_DEPTH`, 2: number of forwarding sources after EX. Index 0 is MEM (nearest), the last index is the oldest. Legal range 1..4.
- `CNT_W`, 16: performance counter width.
- `CLK` in 1: clock.
- `RST` in 1: synchronous, active-high reset.
- `ihit`, `dhit` in 1: instruction and data cache hit.
- `d_rs`, `d_rt` in REG_W: decode-stage source registers.
- `e_rs`, `e_rt` in REG_W: execute-stage source registers.
- `e_memread` in 1: the EX instruction is a load.
- `e_wsel` in REG_W: EX destination register.
- `fwd_wsel` in FWD_DEPTH x REG_W: destination register of each forwarding stage.
- `fwd_wen` in FWD_DEPTH: register-write enable of each forwarding stage.
- `m_memreq` in 1: the MEM instruction is LW or SW.
- `redirect` in 1: branch taken or jump resolved this cycle.
- `w_halt` in 1: halt in writeback.
- `pc_wen` out 1: PC write enable.
- `fd_state`, `de_state`, `em_state`, `mw_state` out 2: `pipe_state_t` (PIPE_ENABLE, PIPE_STALL, PIPE_NOP).
- `fsel_a`, `fsel_b` out `$clog2(FWD_DEPTH+1)`: ALU operand select. 0 means register file; k+1 means stage k.
- `halted` out 1: sticky halt indicator.
- `stall_cnt`, `flush_cnt` out CNT_W: saturating counters.

## Operation
- The state register takes one of four values: RUN, MEMWAIT, REDIR_PEND, HALTED.
- Control outputs are combinational from the current state and the inputs. They are evaluated in the priority order below; the first matching rule wins.
  1. **HALTED, or `w_halt`:** all four latches PIPE_NOP; `pc_wen`=0. Next state is HALTED. HALTED is left only by `RST`.
- 2. **Redirect** (`redirect`, or state REDIR_PEND):
  - With `ihit`: fd, de, em latches PIPE_NOP; mw PIPE_ENABLE; `pc_wen`=1; `flush_cnt`++. Next state is RUN.
  - Without `ihit`: all latches PIPE_STALL; `pc_wen`=0. Next state is REDIR_PEND, so the flush is not lost.
- 3. **`m_memreq && !dhit`:** all latches PIPE_STALL; `pc_wen`=0. Next state is MEMWAIT.
- 4. **`m_memreq && dhit`:** de, em, mw latches PIPE_ENABLE; fd PIPE_ENABLE if `ihit`, otherwise PIPE_NOP. `pc_wen`=`ihit`. Next state is RUN.
- 5. **`!ihit`:** all latches PIPE_STALL; `pc_wen`=0.
- 6. **Load-use:** applies when `e_memread` is set and `e_wsel`!=0 and `e_wsel` equals `d_rs` or `d_rt`. fd PIPE_STALL; de PIPE_NOP (bubble); em and mw PIPE_ENABLE; `pc_wen`=0. This rule is one cycle only: the bubble clears the condition.
- 7. **Otherwise:** all latches PIPE_ENABLE; `pc_wen`=1.
- **Forwarding:** `fsel_a` is k+1 for the lowest k where `fwd_wen[k]` is set, `fwd_wsel[k]`==`e_rs` and `e_rs`!=0; otherwise 0. `fsel_b` follows the same rule using `e_rt`. Forwarding is independent of the state register.
- **`stall_cnt`:** increments in every cycle in which `fd_state`!=PIPE_ENABLE while not HALTED.
- **Both counters:** saturate at all-ones and never wrap.

## Timing
- While `RST` is high, all latch states are PIPE_NOP and `pc_wen`=0. On the next edge: state RUN, `halted`=0, counters 0, `fsel_*` 0.
- Control and fsel outputs have zero latency (combinational). State, `halted` and counters update on the `CLK` rising edge.
- If `redirect` and `w_halt` arrive in the same cycle, halt wins and no flush is counted.
- If `redirect` arrives while in MEMWAIT, it is recorded as REDIR_PEND: the redirect rule outranks the memory-wait rule.
- A second `redirect` while in REDIR_PEND stays pending; one flush is counted.
- `RST` asserted mid-REDIR_PEND or mid-HALTED returns the block to RUN, and the pending redirect is discarded.

## Structure
- `pipe_state_t` and the `hazard_state_t` enum live in `cpu_types_pkg`.
- `LW`, `SW` and the other opcodes stay in that package.
- One sub-module, `fwd_select`, is parametrised by `REG_W` and `FWD_DEPTH` and implements the priority match. It is instantiated twice, for operand A and operand B.

## Test plan
- `FWD_DEPTH`=2. `e_rs`=5, `fwd_wsel`={5,5}, `fwd_wen`={1,1} -> `fsel_a`=1. With `fwd_wen[0]`=0 -> `fsel_a`=2. With `e_rs`=0 -> 0.
- `e_memread`=1, `e_wsel`=3, `d_rt`=3, `ihit`=1 -> one cycle of fd STALL, de NOP, `pc_wen`=0. Next cycle, with EX now a bubble -> all ENABLE.
- `redirect`=1 with `ihit`=0 for 3 cycles, then `ihit`=1 -> 3 cycles of all STALL, then fd/de/em NOP and mw ENABLE. `flush_cnt`=1.
- `m_memreq`=1, `dhit`=0 for 4 cycles, then `dhit`=1 with `ihit`=0 -> 4 cycles of all STALL, then fd NOP and others ENABLE. `stall_cnt`=5.
- `w_halt` pulse for 1 cycle -> `halted`=1 and all NOP indefinitely. Then `RST` -> state RUN, counters 0.
- `CNT_W`=4 with 20 stall cycles -> `stall_cnt` holds at 15.
